// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR link: polynomial, seed, checker states, counter widths.
package lfsr_pkg;

   localparam logic [7:0] TAPS_DEFAULT = 8'b1011_1000;
   localparam logic [7:0] LFSR_SEED    = 8'h97;

   localparam int CNT_W = 4;
   localparam int CHK_W = 8;
   localparam int ERR_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      SYNC   = 2'd2,
      LOCKED = 2'd3
   } chk_state_e;

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-word function of the 8-bit Fibonacci LFSR; shared with the generator.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter logic [7:0] TAPS = TAPS_DEFAULT
) (
   input  logic [7:0] cur,
   output logic [7:0] nxt
);

   assign nxt = {cur[6:0], ^(cur & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: hunts, synchronises, then flywheels and counts mispredictions.
// Build option LFSR_CHK_ZERO_DET_EN: all-zero word in LOCKED is an error and forces HUNT.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter logic [7:0] TAPS       = TAPS_DEFAULT,
   parameter int         LOCK_COUNT = 4,
   parameter int         LOSS_COUNT = 3,
   parameter int         WINDOW     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        start,
   input  logic        valid,
   input  logic [7:0]  data_in,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic        rdy
);

   localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);
   localparam logic [CNT_W-1:0] LOSS_N = CNT_W'(LOSS_COUNT);
   localparam logic [CHK_W-1:0] WIN_N  = CHK_W'(WINDOW);

   chk_state_e        state_q, state_d;
   logic [7:0]        ref_q, ref_d;
   logic [CNT_W-1:0]  match_q, match_d;
   logic [CNT_W-1:0]  miss_q, miss_d;
   logic [CHK_W-1:0]  checked_q, checked_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic              rdy_q, rdy_d;
   logic [7:0]        pred;
   logic              bad;
   logic              zero_word;

   lfsr_step #(.TAPS(TAPS)) u_step (
      .cur (ref_q),
      .nxt (pred)
   );

   assign zero_word = (data_in == 8'h00);

`ifdef LFSR_CHK_ZERO_DET_EN
   assign bad = (data_in != pred) || zero_word;
`else
   assign bad = (data_in != pred);
`endif

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      match_d     = match_q;
      miss_d      = miss_q;
      checked_d   = checked_q;
      locked_d    = locked_q;
      err_d       = 1'b0;
      err_count_d = err_count_q;
      rdy_d       = rdy_q;
      if (ena) begin
         // Dropping start wins over any word presented in the same cycle.
         if (!start) begin
            state_d  = IDLE;
            locked_d = 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  state_d     = HUNT;
                  err_count_d = '0;
                  rdy_d       = 1'b0;
                  match_d     = '0;
                  miss_d      = '0;
                  checked_d   = '0;
               end
               HUNT: begin
                  if (valid && !zero_word) begin
                     ref_d   = data_in;
                     match_d = '0;
                     state_d = SYNC;
                  end
               end
               SYNC: begin
                  if (valid) begin
                     ref_d = data_in;
                     if (data_in == pred) begin
                        if (match_q + 1'b1 == LOCK_N) begin
                           state_d  = LOCKED;
                           locked_d = 1'b1;
                           match_d  = '0;
                           miss_d   = '0;
                        end else begin
                           match_d = match_q + 1'b1;
                        end
                     end else begin
                        match_d = '0;
                     end
                  end
               end
               LOCKED: begin
                  if (valid) begin
                     // Flywheel on the prediction so one corrupt word costs one error.
                     ref_d = pred;
                     if (checked_q != WIN_N) checked_d = checked_q + 1'b1;
                     if (checked_q == WIN_N - 1'b1) rdy_d = 1'b1;
                     if (bad) begin
                        err_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + 1'b1;
`ifdef LFSR_CHK_ZERO_DET_EN
                        if ((miss_q + 1'b1 == LOSS_N) || zero_word) begin
`else
                        if (miss_q + 1'b1 == LOSS_N) begin
`endif
                           state_d  = HUNT;
                           locked_d = 1'b0;
                           match_d  = '0;
                           miss_d   = '0;
                        end else begin
                           miss_d = miss_q + 1'b1;
                        end
                     end else begin
                        miss_d = '0;
                     end
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ref_q       <= '0;
         match_q     <= '0;
         miss_q      <= '0;
         checked_q   <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         match_q     <= match_d;
         miss_q      <= miss_d;
         checked_q   <= checked_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         rdy_q       <= rdy_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_q;
   assign err_count = err_count_q;
   assign rdy       = rdy_q;

endmodule
